// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types for the FIFO access arbiter.
// Holds the control FSM encoding and the read return latency.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RD_LAT = 2;

endpackage

// File: rtl/fifo_access_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant.
// On a tie the requester not served last wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_w,
  input  logic i_req_r,
  output logic o_gnt_w,
  output logic o_gnt_r
);

  logic r_last_wr;

  // grant: single requester wins, tie goes to the one not served last
  always_comb begin
    o_gnt_w = 1'b0;
    o_gnt_r = 1'b0;
    if (i_req_w && i_req_r) begin
      o_gnt_w = !r_last_wr;
      o_gnt_r = r_last_wr;
    end else begin
      o_gnt_w = i_req_w;
      o_gnt_r = i_req_r;
    end
  end

  // remember who was served on the last grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr <= 1'b0;
    end else if (o_gnt_w || o_gnt_r) begin
      r_last_wr <= o_gnt_w;
    end
  end

endmodule

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: shares a single-port SRAM FIFO between
// one writer and one reader, with shadow count and flush drain.
module fifo_access_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int CW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  output logic             flush_done,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_we_n,
  output logic             fifo_oe_n,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_count;
  logic              r_we_n;
  logic [WIDTH-1:0]  r_din;
  logic [RD_LAT-1:0] r_v;
  logic [RD_LAT-1:0] r_disc;
  logic              r_rd_valid;
  logic [WIDTH-1:0]  r_rd_data;

  logic w_run;
  logic w_elig_w;
  logic w_elig_r;
  logic w_gnt_w;
  logic w_gnt_r;
  logic w_flush_rd;
  logic w_issue_rd;
  logic w_in_flight;

  assign full  = (r_count == CW'(DEPTH - 1));
  assign empty = (r_count == '0);
  assign count = r_count;

  assign w_run    = (r_state == RUN);
  assign w_elig_w = w_run && wr_valid && !full;
  assign w_elig_r = w_run && rd_req && !empty;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req_w (w_elig_w),
    .i_req_r (w_elig_r),
    .o_gnt_w (w_gnt_w),
    .o_gnt_r (w_gnt_r)
  );

  assign w_flush_rd  = (r_state == FLUSH) && !empty;
  assign w_issue_rd  = w_gnt_r || w_flush_rd;
  assign w_in_flight = |r_v;

  assign fifo_we_n = r_we_n;
  assign fifo_oe_n = ~r_v[0];
  assign fifo_din  = r_din;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and handshake outputs
  always_comb begin
    w_next     = r_state;
    wr_ready   = 1'b0;
    rd_ready   = 1'b0;
    flush_done = 1'b0;
    unique case (r_state)
      IDLE:  w_next = RUN;
      RUN:   if (flush) w_next = FLUSH;
      FLUSH: if (empty && !w_in_flight) w_next = DONE;
      DONE: begin
        flush_done = 1'b1;
        w_next     = RUN;
      end
    endcase
    wr_ready = w_gnt_w;
    rd_ready = w_gnt_r;
  end

  // shadow occupancy; write and read never accepted together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_gnt_w) begin
      r_count <= r_count + 1'b1;
    end else if (w_issue_rd) begin
      r_count <= r_count - 1'b1;
    end
  end

  // drive write pins for the cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_n <= 1'b1;
      r_din  <= '0;
    end else begin
      r_we_n <= ~w_gnt_w;
      if (w_gnt_w) r_din <= wr_data;
    end
  end

  // read return pipe; discard tag marks flush reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v        <= '0;
      r_disc     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_v        <= {r_v[RD_LAT-2:0], w_issue_rd};
      r_disc     <= {r_disc[RD_LAT-2:0], w_flush_rd};
      r_rd_valid <= r_v[RD_LAT-1] && !r_disc[RD_LAT-1];
      if (r_v[RD_LAT-1] && !r_disc[RD_LAT-1]) begin
        r_rd_data <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter: random + directed bench with a
// queue-based reference model and an SRAM FIFO model.
module tb_fifo_access_arbiter;

  localparam int W = 8;
  localparam int D = 1024;
  localparam int C = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         rd_req;
  logic         rd_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         flush;
  logic         flush_done;
  logic [W-1:0] fifo_din;
  logic         fifo_we_n;
  logic         fifo_oe_n;
  logic [W-1:0] fifo_dout;
  logic [C-1:0] count;
  logic         full;
  logic         empty;

  always #5 clk = ~clk;

  fifo_access_arbiter #(.WIDTH(W), .DEPTH(D), .CW(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .flush      (flush),
    .flush_done (flush_done),
    .fifo_din   (fifo_din),
    .fifo_we_n  (fifo_we_n),
    .fifo_oe_n  (fifo_oe_n),
    .fifo_dout  (fifo_dout),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // SRAM FIFO with synchronous reset and registered dout
  logic [W-1:0] sram_q[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      sram_q.delete();
      fifo_dout <= '0;
    end else begin
      if (!fifo_oe_n && sram_q.size() > 0) fifo_dout <= sram_q.pop_front();
      if (!fifo_we_n) sram_q.push_back(fifo_din);
    end
  end

  // reference model
  typedef struct {
    int           t;
    logic [W-1:0] d;
    bit           disc;
  } ret_t;

  logic [W-1:0] m_q[$];
  ret_t         m_ret[$];
  int           m_mode;
  bit           m_last_wr;
  int           cyc;
  bit           m_we;
  bit           m_oe;
  bit           m_rv;
  logic [W-1:0] m_din;
  logic [W-1:0] m_rd_data;

  function automatic void m_grant(output bit gw, output bit gr);
    bit ew;
    bit er;
    ew = (m_mode == 1) && wr_valid && (m_q.size() < D - 1);
    er = (m_mode == 1) && rd_req && (m_q.size() > 0);
    gw = 1'b0;
    gr = 1'b0;
    if (ew && er) begin
      if (m_last_wr) gr = 1'b1;
      else gw = 1'b1;
    end else begin
      gw = ew;
      gr = er;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ret.delete();
      m_mode    = 0;
      m_last_wr = 1'b0;
      m_we      = 1'b0;
      m_oe      = 1'b0;
      m_rv      = 1'b0;
      m_din     = '0;
      m_rd_data = '0;
    end else begin
      bit gw;
      bit gr;
      bit fr;
      bit busy;
      int nmode;
      m_grant(gw, gr);
      fr = (m_mode == 2) && (m_q.size() > 0);
      busy = 1'b0;
      foreach (m_ret[i]) if (m_ret[i].t > cyc) busy = 1'b1;
      nmode = m_mode;
      case (m_mode)
        0: nmode = 1;
        1: if (flush) nmode = 2;
        2: if (m_q.size() == 0 && !busy) nmode = 3;
        default: nmode = 1;
      endcase
      cyc++;
      m_we = gw;
      m_oe = gr || fr;
      if (gw) begin
        m_din = wr_data;
        m_q.push_back(wr_data);
        m_last_wr = 1'b1;
      end
      if (gr || fr) begin
        ret_t r;
        r.t    = cyc + 2;
        r.d    = m_q.pop_front();
        r.disc = fr;
        m_ret.push_back(r);
        if (gr) m_last_wr = 1'b0;
      end
      m_rv = 1'b0;
      while (m_ret.size() > 0 && m_ret[0].t <= cyc) begin
        if (m_ret[0].t == cyc && !m_ret[0].disc) begin
          m_rv      = 1'b1;
          m_rd_data = m_ret[0].d;
        end
        void'(m_ret.pop_front());
      end
      m_mode = nmode;
    end
  end

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit gw;
      bit gr;
      m_grant(gw, gr);
      chk("wr_ready",   32'(wr_ready),   32'(gw));
      chk("rd_ready",   32'(rd_ready),   32'(gr));
      chk("count",      32'(count),      32'(m_q.size()));
      chk("full",       32'(full),       32'(m_q.size() == D - 1));
      chk("empty",      32'(empty),      32'(m_q.size() == 0));
      chk("flush_done", 32'(flush_done), 32'(m_mode == 3));
      chk("fifo_we_n",  32'(fifo_we_n),  32'(!m_we));
      chk("fifo_oe_n",  32'(fifo_oe_n),  32'(!m_oe));
      chk("fifo_din",   32'(fifo_din),   32'(m_din));
      chk("rd_valid",   32'(rd_valid),   32'(m_rv));
      chk("rd_data",    32'(rd_data),    32'(m_rd_data));
    end
  end

  // directed-test logs
  bit           log_en = 1'b0;
  bit           rv_watch = 1'b0;
  int           rv_seen = 0;
  int           ecount = 0;
  bit           glog[$];
  int           acc[$];
  int           lat[$];
  logic [W-1:0] rdlog[$];

  always @(posedge clk) begin
    ecount++;
    if (log_en) begin
      if (wr_valid && wr_ready) glog.push_back(1'b0);
      if (rd_req && rd_ready) begin
        glog.push_back(1'b1);
        acc.push_back(ecount);
      end
    end
  end

  always @(negedge clk) begin
    if (log_en && rd_valid && acc.size() > 0) begin
      lat.push_back(ecount - acc.pop_front());
      rdlog.push_back(rd_data);
    end
    if (rv_watch && rd_valid) rv_seen++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_flush(output int nd, output int nrv,
                           output int nwr, output int noe,
                           output int ok);
    nd  = 0;
    nrv = 0;
    nwr = 0;
    noe = 0;
    ok  = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (rd_valid) nrv++;
      if (wr_ready) nwr++;
      if (!fifo_oe_n) noe++;
      if (flush_done) begin
        nd++;
        ok = 1;
        break;
      end
      step();
    end
    wr_valid = 1'b0;
    step();
    if (flush_done) nd++;
  endtask

  initial begin
    int nd;
    int nrv;
    int nwr;
    int noe;
    int ok;
    int k;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    wr_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) step();
    chk("rst_we_n",  32'(fifo_we_n), 32'd1);
    chk("rst_oe_n",  32'(fifo_oe_n), 32'd1);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    rst_n = 1'b1;
    step();
    chk("idle_count", 32'(count),     32'd0);
    chk("idle_empty", 32'(empty),     32'd1);
    chk("idle_we_n",  32'(fifo_we_n), 32'd1);
    chk("idle_oe_n",  32'(fifo_oe_n), 32'd1);

    // write A5, 3C then read twice
    log_en = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'hA5;
    step();
    chk("wr1_count", 32'(count), 32'd1);
    wr_data = 8'h3C;
    step();
    chk("wr2_count", 32'(count), 32'd2);
    wr_valid = 1'b0;
    rd_req = 1'b1;
    step();
    chk("rd1_count", 32'(count), 32'd1);
    step();
    chk("rd2_count", 32'(count), 32'd0);
    rd_req = 1'b0;
    repeat (4) step();
    chk("ret_n", 32'(rdlog.size()), 32'd2);
    if (rdlog.size() == 2) begin
      chk("ret0_data", 32'(rdlog[0]), 32'h00A5);
      chk("ret1_data", 32'(rdlog[1]), 32'h003C);
      chk("ret0_lat", 32'(lat[0]), 32'd2);
      chk("ret1_lat", 32'(lat[1]), 32'd2);
    end
    log_en = 1'b0;

    // store 4 words with a read served last, then tie for 6 cycles
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = W'($urandom);
      step();
    end
    wr_valid = 1'b0;
    rd_req = 1'b1;
    step();
    glog.delete();
    log_en = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = W'($urandom);
      step();
    end
    wr_valid = 1'b0;
    rd_req = 1'b0;
    log_en = 1'b0;
    chk("tie_n", 32'(glog.size()), 32'd6);
    if (glog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("tie_grant", 32'(glog[i]), 32'(i % 2));
      end
    end
    chk("tie_count", 32'(count), 32'd4);
    repeat (4) step();

    // random traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      wr_valid = ($urandom_range(0, 99) < 55);
      rd_req   = ($urandom_range(0, 99) < 45);
      wr_data  = W'($urandom);
      flush    = ($urandom_range(0, 59) == 0);
      step();
    end
    wr_valid = 1'b0;
    rd_req = 1'b0;
    flush = 1'b0;
    k = 0;
    while (m_mode != 1 && k < 3000) begin
      step();
      k++;
    end
    repeat (4) step();

    // drain, then fill to the boundary
    run_flush(nd, nrv, nwr, noe, ok);
    chk("drain_done", 32'(ok), 32'd1);
    wr_valid = 1'b1;
    k = 0;
    while (m_q.size() < D - 1 && k < 1200) begin
      wr_data = W'($urandom);
      step();
      k++;
    end
    #1;
    chk("fill_count", 32'(count),    32'd1023);
    chk("fill_full",  32'(full),     32'd1);
    chk("fill_wrrdy", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    step();
    run_flush(nd, nrv, nwr, noe, ok);
    chk("big_flush_done", 32'(ok),    32'd1);
    chk("big_flush_cnt",  32'(count), 32'd0);
    rd_req = 1'b1;
    #1;
    chk("empty_rdrdy", 32'(rd_ready), 32'd0);
    chk("empty_flag",  32'(empty),    32'd1);
    rd_req = 1'b0;
    step();

    // flush with 5 words stored
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = W'($urandom);
      step();
    end
    wr_valid = 1'b0;
    chk("f5_count0", 32'(count), 32'd5);
    run_flush(nd, nrv, nwr, noe, ok);
    chk("f5_seen",   32'(ok),    32'd1);
    chk("f5_pulses", 32'(nd),    32'd1);
    chk("f5_reads",  32'(noe),   32'd5);
    chk("f5_rvalid", 32'(nrv),   32'd0);
    chk("f5_wrrdy",  32'(nwr),   32'd0);
    chk("f5_count",  32'(count), 32'd0);

    // reset one cycle after a read accept
    wr_valid = 1'b1;
    wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    rv_watch = 1'b1;
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    rv_watch = 1'b0;
    chk("rst_mid_rv",    32'(rv_seen), 32'd0);
    chk("rst_mid_count", 32'(count),   32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Shares the single-port SRAM-backed FIFO between one write requester and one read requester, because the FIFO accepts only one operation per cycle. The block owns the FIFO's `we_n`/`oe_n`/`din` pins and keeps a shadow occupancy count so it never issues a write when full or a read when empty. It offers valid/ready handshakes upstream and returns read data with fixed latency. It also provides a flush sequence that drains the FIFO.

## Interface
- `WIDTH`, 8, data width; must match the FIFO.
- `DEPTH`, 1024, FIFO depth. FIFO full is declared at `DEPTH-1` entries.
- `CW`, 10, count width; `2**CW >= DEPTH`.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous assert, active-low.
- `wr_valid` in 1: write request.
- `wr_data` in WIDTH: write payload.
- `wr_ready` out 1: write accepted this cycle when `wr_valid && wr_ready`.
- `rd_req` in 1: read request.
- `rd_ready` out 1: read accepted this cycle when `rd_req && rd_ready`.
- `rd_valid` out 1: one-cycle pulse marking `rd_data` valid.
- `rd_data` out WIDTH: returned word.
- `flush` in 1: pulse; starts a drain.
- `flush_done` out 1: one-cycle pulse when the drain completes.
- `fifo_din` out WIDTH: drives the FIFO `din`.
- `fifo_we_n` out 1: drives the FIFO `we_n`.
- `fifo_oe_n` out 1: drives the FIFO `oe_n`.
- `fifo_dout` in WIDTH: FIFO `dout`.
- `count` out CW: shadow occupancy.
- `full` out 1: `count == DEPTH-1`.
- `empty` out 1: `count == 0`.

## Operation
**FSM states:** `IDLE`, `RUN`, `FLUSH`, `DONE`.
- `IDLE` lasts one cycle after reset release, then the FSM moves to `RUN`.
- `RUN`: normal arbitration.
- `flush` sampled high in `RUN` → `FLUSH`.
- `FLUSH` → `DONE` once `count == 0` and no read is in flight.
- `DONE`: asserts `flush_done` for one cycle, then returns to `RUN`.

**Eligibility**
- Write is eligible when `state == RUN`, `wr_valid` is high and `!full`.
- Read is eligible when `state == RUN`, `rd_req` is high and `!empty`.

**Grant rules**
- If only one requester is eligible, it is granted.
- If both are eligible, round-robin on a `last_wr` bit: grant the requester that was not served last.
- `last_wr` resets to 0, so the first tie goes to the write.
- `wr_ready` and `rd_ready` are combinational from the grant, and at most one is high per cycle.

**Issue**
- An accepted op is registered onto the FIFO pins for exactly the next cycle:
  - accepted write: `fifo_we_n = 0`, `fifo_oe_n = 1`, `fifo_din = wr_data`;
  - accepted read: `fifo_oe_n = 0`, `fifo_we_n = 1`.
- Otherwise both pins are 1 and `fifo_din` holds its last value.

**Count**
- +1 on write accept, −1 on read accept.
- Never both in the same cycle. No wrap: eligibility prevents overflow and underflow.

**Flush**
- In `FLUSH`, `wr_ready` and `rd_ready` are 0.
- The block self-issues one read per cycle while `!empty`.
- Returned data is discarded: `rd_valid` is suppressed for flush reads.
- Reads accepted before entering `FLUSH` still return with `rd_valid`.
- `flush` is ignored outside `RUN`. A flush with an empty FIFO reaches `DONE` in 1 cycle, or later if reads are in flight.

## Timing
- **Write:** accepted at edge E0; FIFO write occurs at edge E1.
- **Read:** accepted at E0 → `fifo_oe_n` low in the cycle after E0 → SRAM output valid after E1 → `rd_data` registered at E2 → `rd_valid` high for the cycle after E2.
  - Accept-to-`rd_valid` latency is 2 edges.
- **Back-to-back:** accepts are allowed every cycle. Read returns are pipelined through a 2-stage valid shift register tagged with a discard bit for flush reads.
- **Consumer:** no backpressure on `rd_valid`; the consumer must take the data.
- **Reset:** asynchronous assert, synchronous release. While `rst_n == 0`:
  - `fifo_we_n = fifo_oe_n = 1`;
  - `fifo_din = 0`, `rd_data = 0`;
  - `rd_valid = 0`, `flush_done = 0`;
  - `count = 0`, `empty = 1`, `full = 0`;
  - `wr_ready = rd_ready = 0`;
  - state = `IDLE`, `last_wr = 0`.
- **Reset mid-operation:** in-flight reads are dropped. The FIFO's own synchronous reset must be driven from the same `rst_n` so its pointers realign.

## Structure
- Package `fifo_ctrl_pkg` holds:
  - the state encoding (`IDLE = 2'd0`, `RUN = 2'd1`, `FLUSH = 2'd2`, `DONE = 2'd3`);
  - the read-latency constant `RD_LAT = 2`.
- One sub-module, `rr_arb2`: 2-requester round-robin with a `last` bit, purely grant logic plus the `last` register.
- The top level instantiates `rr_arb2` and the FIFO. The FIFO is instantiated alongside, not inside, the block.

## Test plan
- **Reset then idle:** all outputs hold their reset values. After release, `count = 0`, `empty = 1` and both FIFO pins are 1.
- **Write 0xA5, 0x3C, then read twice:**
  - `count` goes 0→1→2→1→0;
  - `rd_data` returns 0xA5 then 0x3C;
  - each `rd_valid` arrives 2 edges after its accept.
- **Simultaneous requests with 4 words stored and `wr_valid`, `rd_req` held high for 6 cycles:** grants alternate W,R,W,R,W,R and `count` ends at 4.
- **Fill boundary:**
  - write until `count = DEPTH-1` (1023);
  - next `wr_valid` → `wr_ready = 0` and `full = 1`;
  - `rd_req` on empty → `rd_ready = 0`.
- **Flush with 5 words stored:**
  - `flush` pulse → 5 self-issued reads with no `rd_valid`;
  - `flush_done` pulses once and `count = 0`;
  - `wr_ready` is held 0 throughout.
- **Reset mid-read:** `rst_n` asserted one cycle after a read accept → no `rd_valid` ever appears and `count = 0`.
